// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, widths and the packed command record for the ALU
//            issue stage.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] OP_AND = 2'b00;
    localparam logic [SEL_W-1:0] OP_OR  = 2'b01;
    localparam logic [SEL_W-1:0] OP_ADD = 2'b10;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b11;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issue_if
// Brief    : Command, ALU and result buses of the issue stage. out_zero is
//            present only when ALU_ZERO_FLAG_EN is defined.
// Revision : 1.0
// ============================================================================
interface alu_cmd_issue_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SEL_W  = alu_pkg::SEL_W,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_y;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic [SEL_W-1:0]  out_sel;
    logic [LVL_W-1:0]  fifo_level;
`ifdef ALU_ZERO_FLAG_EN
    logic              out_zero;
`endif

    // The issue stage itself
    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel,
`ifdef ALU_ZERO_FLAG_EN
        output out_zero,
`endif
        output fifo_level
    );

    // Producer, ALU and consumer around it
    modport master (
        output in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel,
`ifdef ALU_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  fifo_level
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Brief    : Synchronous FIFO of alu_cmd_t with explicit level tracking.
// Revision : 1.0
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push_i,
    input  wire logic                   pop_i,
    input  wire alu_cmd_t               wdata_i,
    output alu_cmd_t                    rdata_o,
    output logic [$clog2(DEPTH):0]      level_o,
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    alu_cmd_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issue
// Brief    : Buffers ALU commands, drives the head onto the ALU and registers
//            the result behind a valid/ready handshake. ALU_ZERO_FLAG_EN adds
//            a registered out_zero flag.
// Revision : 1.0
// ============================================================================
module alu_cmd_issue #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SEL_W  = alu_pkg::SEL_W,
    parameter int DEPTH  = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    alu_cmd_issue_if.slave bus
);
    import alu_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e        state_q, state_d;
    alu_cmd_t          w_head;
    alu_cmd_t          w_wdata;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_fire;
    logic [LVL_W-1:0]  w_level;
    logic [DATA_W-1:0] out_y_q;
    logic [SEL_W-1:0]  out_sel_q;

    assign w_wdata = '{sel: bus.in_sel, b: bus.in_b, a: bus.in_a};
    assign w_push  = bus.in_valid && !w_full;
    // Capture whenever a command waits and the output slot is free or draining
    assign w_fire  = !w_empty && ((state_q == ST_EMPTY) || bus.out_ready);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_fire),
        .wdata_i (w_wdata),
        .rdata_o (w_head),
        .level_o (w_level),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign bus.in_ready   = !w_full;
    assign bus.fifo_level = w_level;
    assign bus.alu_a      = w_empty ? '0 : w_head.a;
    assign bus.alu_b      = w_empty ? '0 : w_head.b;
    assign bus.alu_sel    = w_empty ? '0 : w_head.sel;
    assign bus.out_valid  = (state_q == ST_FULL);
    assign bus.out_y      = out_y_q;
    assign bus.out_sel    = out_sel_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_fire) state_d = ST_FULL;
            ST_FULL: begin
                if (w_fire)             state_d = ST_FULL;
                else if (bus.out_ready) state_d = ST_EMPTY;
            end
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_y_q   <= '0;
            out_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_fire) begin
                out_y_q   <= bus.alu_y;
                out_sel_q <= w_head.sel;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic out_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_zero_q <= 1'b0;
        else if (w_fire) out_zero_q <= (bus.alu_y == '0);
    end

    assign bus.out_zero = out_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issue
// Brief    : Self-checking bench for alu_cmd_issue against a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] b;
        logic [3:0] a;
    } m_cmd_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] exp_y;
        logic       exp_z;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    m_cmd_t     m_q[$];
    logic       m_slot_v;
    logic [3:0] m_slot_y;
    logic [1:0] m_slot_sel;
    logic       m_slot_z;

    alu_cmd_issue_if #(.DATA_W(4), .SEL_W(2), .DEPTH(DEPTH)) bus ();

    alu_cmd_issue #(.DATA_W(4), .SEL_W(2), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The combinational mini ALU the stage feeds
    always_comb begin
        case (bus.alu_sel)
            2'b00:   bus.alu_y = bus.alu_a & bus.alu_b;
            2'b01:   bus.alu_y = bus.alu_a | bus.alu_b;
            2'b10:   bus.alu_y = bus.alu_a + bus.alu_b;
            default: bus.alu_y = bus.alu_a - bus.alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_y(input m_cmd_t c);
        int r;
        case (c.sel)
            2'd0:    r = int'(c.a) & int'(c.b);
            2'd1:    r = int'(c.a) | int'(c.b);
            2'd2:    r = (int'(c.a) + int'(c.b)) % 16;
            default: r = (int'(c.a) - int'(c.b) + 16) % 16;
        endcase
        return r[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_slot_v   = 1'b0;
        m_slot_y   = '0;
        m_slot_sel = '0;
        m_slot_z   = 1'b0;
    endtask

    task automatic check_state();
        m_cmd_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk("in_ready",   32'(bus.in_ready),   32'(m_q.size() != DEPTH));
        chk("fifo_level", 32'(bus.fifo_level), 32'(m_q.size()));
        chk("alu_a",      32'(bus.alu_a),      32'(h.a));
        chk("alu_b",      32'(bus.alu_b),      32'(h.b));
        chk("alu_sel",    32'(bus.alu_sel),    32'(h.sel));
        chk("out_valid",  32'(bus.out_valid),  32'(m_slot_v));
        chk("out_y",      32'(bus.out_y),      32'(m_slot_y));
        chk("out_sel",    32'(bus.out_sel),    32'(m_slot_sel));
`ifdef ALU_ZERO_FLAG_EN
        chk("out_zero",   32'(bus.out_zero),   32'(m_slot_z));
`endif
    endtask

    // Drive one cycle's inputs, check, advance model and clock to next negedge
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] sel, input logic ordy);
        bit     push;
        bit     fire;
        m_cmd_t c;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sel    = sel;
        bus.out_ready = ordy;
        #1;
        check_state();
        if (rst_n) begin
            push = v && (m_q.size() != DEPTH);
            fire = (m_q.size() > 0) && (!m_slot_v || ordy);
            if (fire) begin
                c          = m_q.pop_front();
                m_slot_y   = ref_y(c);
                m_slot_sel = c.sel;
                m_slot_z   = (ref_y(c) == 4'd0);
                m_slot_v   = 1'b1;
            end else if (ordy) begin
                m_slot_v = 1'b0;
            end
            if (push) m_q.push_back('{sel: sel, b: b, a: a});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'h0, 4'h0, 2'b00, ordy);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{a: 4'h6, b: 4'h3, sel: 2'b00, exp_y: 4'h2, exp_z: 1'b0};
        vecs[1] = '{a: 4'h9, b: 4'h9, sel: 2'b10, exp_y: 4'h2, exp_z: 1'b0};
        vecs[2] = '{a: 4'h3, b: 4'h5, sel: 2'b11, exp_y: 4'hE, exp_z: 1'b0};
        vecs[3] = '{a: 4'hA, b: 4'h5, sel: 2'b01, exp_y: 4'hF, exp_z: 1'b0};
        vecs[4] = '{a: 4'hC, b: 4'h3, sel: 2'b00, exp_y: 4'h0, exp_z: 1'b1};
        vecs[5] = '{a: 4'h1, b: 4'h1, sel: 2'b10, exp_y: 4'h2, exp_z: 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset out_valid",  32'(bus.out_valid),  32'd0);
        chk("reset fifo_level", 32'(bus.fifo_level), 32'd0);
        chk("reset out_y",      32'(bus.out_y),      32'd0);
        chk("reset out_sel",    32'(bus.out_sel),    32'd0);
        chk("reset in_ready",   32'(bus.in_ready),   32'd1);
        rst_n = 1'b1;

        // Table: one command at a time, result two cycles after accept
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
            chk("vec out_valid early", 32'(bus.out_valid), 32'd0);
            idle(1'b1);
            chk("vec out_valid", 32'(bus.out_valid), 32'd1);
            chk("vec out_y",     32'(bus.out_y),     32'(vecs[i].exp_y));
            chk("vec out_sel",   32'(bus.out_sel),   32'(vecs[i].sel));
`ifdef ALU_ZERO_FLAG_EN
            chk("vec out_zero",  32'(bus.out_zero),  32'(vecs[i].exp_z));
`endif
            idle(1'b1);
        end

        // Back-to-back ADD then SUB, one result per cycle
        step(1'b1, 4'h9, 4'h9, 2'b10, 1'b1);
        step(1'b1, 4'h3, 4'h5, 2'b11, 1'b1);
        chk("b2b first y",  32'(bus.out_y), 32'h2);
        idle(1'b1);
        chk("b2b second y", 32'(bus.out_y), 32'hE);
        chk("b2b second v", 32'(bus.out_valid), 32'd1);
        idle(1'b1);

        // Backpressure: five accepted, sixth refused
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 1), 4'h2, 2'b10, 1'b0);
        chk("full fifo_level", 32'(bus.fifo_level), 32'd4);
        chk("full in_ready",   32'(bus.in_ready),   32'd0);
        chk("full out_y",      32'(bus.out_y),      32'h3);
        step(1'b1, 4'h7, 4'h1, 2'b10, 1'b0);
        chk("sixth refused", 32'(bus.fifo_level), 32'd4);
        step(1'b1, 4'h7, 4'h1, 2'b10, 1'b1);
        chk("after pulse in_ready", 32'(bus.in_ready), 32'd1);
        chk("after pulse out_y",    32'(bus.out_y),    32'h4);
        step(1'b1, 4'h7, 4'h1, 2'b10, 1'b1);
        repeat (8) idle(1'b1);
        chk("drained level", 32'(bus.fifo_level), 32'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 4'h5, 4'(i), 2'b01, 1'b0);
        chk("pre-reset out_valid", 32'(bus.out_valid),  32'd1);
        chk("pre-reset level",     32'(bus.fifo_level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid),  32'd0);
        chk("async rst level",     32'(bus.fifo_level), 32'd0);
        chk("async rst out_y",     32'(bus.out_y),      32'd0);
        model_reset();
        @(negedge clk);
        idle(1'b0);
        rst_n = 1'b1;
        step(1'b1, 4'hA, 4'h5, 2'b01, 1'b1);
        idle(1'b1);
        chk("post-reset OR y", 32'(bus.out_y), 32'hF);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 2'($urandom), ($urandom_range(0, 2) != 0));
        end
        repeat (8) idle(1'b1);
        chk("final level",     32'(bus.fifo_level), 32'd0);
        chk("final out_valid", 32'(bus.out_valid),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
